// File: rtl/program_mem_arbiter_if.sv
// Consumer and program-memory read channel bundle for the arbiter.
// master: arbiter side; slave: fetch units plus program memory.
interface program_mem_arbiter_if #(
  parameter int NUM_CONSUMERS         = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
);
  localparam int NC = NUM_CONSUMERS;
  localparam int AW = PROGRAM_MEM_ADDR_BITS;
  localparam int DW = PROGRAM_MEM_DATA_BITS;

  logic [NC-1:0]         consumer_read_valid;
  logic [NC-1:0][AW-1:0] consumer_read_address;
  logic [NC-1:0]         consumer_read_ready;
  logic [NC-1:0][DW-1:0] consumer_read_data;
  logic                  program_mem_read_valid;
  logic [AW-1:0]         program_mem_read_address;
  logic                  program_mem_read_ready;
  logic [DW-1:0]         program_mem_read_data;

  modport master (
    input  consumer_read_valid,
    input  consumer_read_address,
    output consumer_read_ready,
    output consumer_read_data,
    output program_mem_read_valid,
    output program_mem_read_address,
    input  program_mem_read_ready,
    input  program_mem_read_data
  );

  modport slave (
    output consumer_read_valid,
    output consumer_read_address,
    input  consumer_read_ready,
    input  consumer_read_data,
    input  program_mem_read_valid,
    input  program_mem_read_address,
    output program_mem_read_ready,
    output program_mem_read_data
  );
endinterface

// File: rtl/program_mem_arbiter.sv
// Round-robin arbiter sharing one program-memory read channel.
// Ports: clk, reset (sync, high), bus (master), busy, grant_id.
module program_mem_arbiter #(
  parameter int NUM_CONSUMERS         = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  localparam int GW = (NUM_CONSUMERS > 1) ?
                      $clog2(NUM_CONSUMERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  program_mem_arbiter_if.master bus,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);
  localparam int NC = NUM_CONSUMERS;
  localparam int AW = PROGRAM_MEM_ADDR_BITS;
  localparam int DW = PROGRAM_MEM_DATA_BITS;

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    RELAY,
    RELEASE
  } state_t;

  state_t                r_state;
  logic [GW-1:0]         r_rr_ptr;
  logic [GW-1:0]         r_grant;
  logic                  r_busy;
  logic                  r_mem_valid;
  logic [AW-1:0]         r_mem_addr;
  logic [NC-1:0]         r_ready;
  logic [NC-1:0][DW-1:0] r_data;

  logic                  w_hit_hi;
  logic                  w_hit_lo;
  logic [GW-1:0]         w_pick_hi;
  logic [GW-1:0]         w_pick_lo;
  logic [GW-1:0]         w_pick;
  logic [GW-1:0]         w_next_ptr;

  // Two searches: lowest requester at or above rr_ptr, and lowest
  // overall as the wrap-around fallback. Descending loop so the
  // lowest index is the last one written.
  always_comb begin
    w_hit_hi  = 1'b0;
    w_hit_lo  = 1'b0;
    w_pick_hi = '0;
    w_pick_lo = '0;
    for (int i = NC - 1; i >= 0; i--) begin
      if (bus.consumer_read_valid[i]) begin
        w_hit_lo  = 1'b1;
        w_pick_lo = GW'(i);
        if (GW'(i) >= r_rr_ptr) begin
          w_hit_hi  = 1'b1;
          w_pick_hi = GW'(i);
        end
      end
    end
  end

  assign w_pick     = w_hit_hi ? w_pick_hi : w_pick_lo;
  assign w_next_ptr = (r_grant == GW'(NC - 1)) ?
                      '0 : r_grant + GW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_ready     <= '0;
      r_data      <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_hit_lo) begin
            r_mem_valid <= 1'b1;
            r_mem_addr  <= bus.consumer_read_address[w_pick];
            r_grant     <= w_pick;
            r_busy      <= 1'b1;
            r_state     <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (bus.program_mem_read_ready) begin
            r_mem_valid      <= 1'b0;
            r_data[r_grant]  <= bus.program_mem_read_data;
            r_ready[r_grant] <= 1'b1;
            r_state          <= RELAY;
          end
        end
        RELAY: begin
          r_ready <= '0;
          r_state <= RELEASE;
        end
        RELEASE: begin
          // Fetch units drop valid a couple of cycles after the
          // pulse; hold off so that stale valid is not re-granted.
          if (!bus.consumer_read_valid[r_grant]) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.consumer_read_ready      = r_ready;
  assign bus.consumer_read_data       = r_data;
  assign bus.program_mem_read_valid   = r_mem_valid;
  assign bus.program_mem_read_address = r_mem_addr;
  assign busy                         = r_busy;
  assign grant_id                     = r_grant;
endmodule

// File: tb/tb_program_mem_arbiter.sv
// Scoreboard bench for program_mem_arbiter.
// Drives/samples on negedge; memory and fetch units modelled here.
module tb_program_mem_arbiter;
  localparam int NC = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [1:0] grant_id;

  program_mem_arbiter_if #(
    .NUM_CONSUMERS(NC),
    .PROGRAM_MEM_ADDR_BITS(AW),
    .PROGRAM_MEM_DATA_BITS(DW)
  ) bus ();

  program_mem_arbiter #(
    .NUM_CONSUMERS(NC),
    .PROGRAM_MEM_ADDR_BITS(AW),
    .PROGRAM_MEM_DATA_BITS(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t                  q[$];
  exp_t                  cur;
  int                    checks = 0;
  int                    failures = 0;
  int                    pulses = 0;
  int                    reqs = 0;
  logic [NC-1:0][DW-1:0] shadow;
  int                    hold[NC];
  int                    drop_cnt[NC];
  int                    rearm_left[NC];
  bit                    rearm_pend[NC];
  logic [AW-1:0]         rearm_addr[NC];
  int                    mem_lat = 1;
  int                    lat = 0;
  bit                    spurious = 0;
  bit                    agent_en = 0;
  logic                  prev_mem_valid = 1'b0;
  logic [NC-1:0]         prev_ready = '0;
  int                    last_id = 0;
  logic [AW-1:0]         last_addr = '0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_fn(logic [AW-1:0] a);
    if (a == 8'h15) return 16'hA5C3;
    return {a ^ 8'h5A, ~a};
  endfunction

  task automatic expect_grant(int id, logic [AW-1:0] a);
    exp_t e;
    e.id   = id;
    e.addr = a;
    e.data = mem_fn(a);
    q.push_back(e);
  endtask

  task automatic req(int id, logic [AW-1:0] a);
    bus.consumer_read_valid[id]   = 1'b1;
    bus.consumer_read_address[id] = a;
  endtask

  task automatic clear_agent();
    for (int i = 0; i < NC; i++) begin
      drop_cnt[i]   = 0;
      rearm_left[i] = 0;
      rearm_pend[i] = 1'b0;
      hold[i]       = 2;
    end
    q.delete();
    bus.consumer_read_valid  = '0;
    bus.program_mem_read_ready = 1'b0;
    lat      = 0;
    spurious = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (agent_en) begin
      for (int i = 0; i < NC; i++) begin
        if (rearm_pend[i]) begin
          rearm_pend[i] = 1'b0;
          req(i, rearm_addr[i]);
        end else if (drop_cnt[i] > 0) begin
          drop_cnt[i]--;
          if (drop_cnt[i] == 0) begin
            bus.consumer_read_valid[i] = 1'b0;
            if (rearm_left[i] > 0) begin
              rearm_left[i]--;
              rearm_pend[i] = 1'b1;
            end
          end
        end
      end
      if (bus.program_mem_read_valid && !prev_mem_valid) begin
        reqs++;
        check("req_expected", 64'(q.size() != 0), 64'(1));
        if (q.size() != 0) begin
          cur = q.pop_front();
          check("req_addr", bus.program_mem_read_address, cur.addr);
          check("req_grant", grant_id, cur.id);
          last_id   = cur.id;
          last_addr = cur.addr;
        end
      end else if (bus.program_mem_read_valid) begin
        check("addr_stable", bus.program_mem_read_address, cur.addr);
      end
      if (bus.consumer_read_ready != '0) begin
        check("ready_one_cycle", prev_ready, 0);
        check("ready_onehot", bus.consumer_read_ready,
              64'(1) << cur.id);
        shadow[cur.id] = cur.data;
        check("read_data", bus.consumer_read_data, shadow);
        pulses++;
        drop_cnt[cur.id] = hold[cur.id];
      end
      if (bus.program_mem_read_ready) begin
        bus.program_mem_read_ready = 1'b0;
        lat = 0;
      end else if (bus.program_mem_read_valid) begin
        if (lat >= mem_lat - 1) begin
          bus.program_mem_read_ready = 1'b1;
          bus.program_mem_read_data  =
            mem_fn(bus.program_mem_read_address);
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
        if (spurious) begin
          spurious = 1'b0;
          bus.program_mem_read_ready = 1'b1;
          bus.program_mem_read_data  = 16'hDEAD;
        end
      end
    end
    prev_mem_valid = bus.program_mem_read_valid;
    prev_ready     = bus.consumer_read_ready;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_mvalid"}, bus.program_mem_read_valid, 0);
    check({tag, "_maddr"}, bus.program_mem_read_address, 0);
    check({tag, "_ready"}, bus.consumer_read_ready, 0);
    check({tag, "_data"}, bus.consumer_read_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant"}, grant_id, 0);
  endtask

  task automatic start_run();
    shadow         = '0;
    prev_mem_valid = 1'b0;
    prev_ready     = '0;
    reset          = 1'b0;
    agent_en       = 1'b1;
  endtask

  task automatic do_reset(int cycles);
    agent_en = 1'b0;
    reset    = 1'b1;
    clear_agent();
    repeat (cycles) @(negedge clk);
    check_zero("reset");
    start_run();
  endtask

  task automatic wait_pulses(int target, int budget);
    int n = 0;
    while (pulses < target && n < budget) begin
      tick();
      n++;
    end
    check("pulse_count", pulses, target);
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("back_to_idle", busy, 0);
  endtask

  initial begin
    int p0;
    int r0;
    reset = 1'b1;
    bus.consumer_read_valid    = '0;
    bus.consumer_read_address  = '0;
    bus.program_mem_read_ready = 1'b0;
    bus.program_mem_read_data  = '0;
    clear_agent();

    // reset with random inputs
    repeat (2) begin
      bus.consumer_read_valid    = 4'($urandom);
      bus.consumer_read_address  = $urandom;
      bus.program_mem_read_ready = 1'($urandom);
      bus.program_mem_read_data  = 16'($urandom);
      @(negedge clk);
    end
    check_zero("reset_rand");
    clear_agent();
    start_run();
    repeat (3) tick();
    check("idle_no_req", bus.program_mem_read_valid, 0);
    check("idle_busy", busy, 0);

    // single request, memory latency 3
    mem_lat = 3;
    expect_grant(2, 8'h15);
    req(2, 8'h15);
    tick();
    check("mvalid_rise", bus.program_mem_read_valid, 1);
    repeat (3) tick();
    check("ready_pulse_c2", bus.consumer_read_ready, 4'b0100);
    check("data_c2", bus.consumer_read_data[2], 16'hA5C3);
    tick();
    check("ready_drop", bus.consumer_read_ready, 0);
    wait_pulses(1, 20);
    wait_idle(20);

    // simultaneous requests from a fresh rr_ptr
    do_reset(2);
    mem_lat = 1;
    for (int i = 0; i < NC; i++) begin
      expect_grant(i, 8'(8'h10 + i));
      req(i, 8'(8'h10 + i));
    end
    wait_pulses(pulses + 4, 200);
    wait_idle(20);
    expect_grant(0, 8'h40);
    expect_grant(3, 8'h43);
    req(0, 8'h40);
    req(3, 8'h43);
    wait_pulses(pulses + 2, 100);
    wait_idle(20);

    // fairness: consumer 1 re-requests while 3 waits
    expect_grant(0, 8'h50);
    req(0, 8'h50);
    wait_pulses(pulses + 1, 50);
    wait_idle(20);
    rearm_left[1] = 1;
    rearm_addr[1] = 8'h62;
    expect_grant(1, 8'h61);
    expect_grant(3, 8'h63);
    expect_grant(1, 8'h62);
    req(1, 8'h61);
    req(3, 8'h63);
    wait_pulses(pulses + 3, 150);
    wait_idle(20);

    // stale valid held 3 cycles after the pulse
    hold[0] = 3;
    p0 = pulses;
    r0 = reqs;
    expect_grant(0, 8'h30);
    req(0, 8'h30);
    wait_pulses(pulses + 1, 50);
    wait_idle(20);
    repeat (6) tick();
    check("stale_reqs", reqs - r0, 1);
    check("stale_pulses", pulses - p0, 1);
    hold[0] = 2;

    // spurious memory ready while idle
    spurious = 1'b1;
    repeat (3) tick();
    check("spur_mvalid", bus.program_mem_read_valid, 0);
    check("spur_busy", busy, 0);
    check("spur_ready", bus.consumer_read_ready, 0);
    check("spur_data", bus.consumer_read_data, shadow);
    check("spur_grant", grant_id, last_id);
    check("spur_maddr", bus.program_mem_read_address, last_addr);

    // reset while a memory read is outstanding
    mem_lat = 20;
    expect_grant(2, 8'h22);
    req(2, 8'h22);
    begin
      int n = 0;
      while (!bus.program_mem_read_valid && n < 20) begin
        tick();
        n++;
      end
    end
    check("mw_req", bus.program_mem_read_valid, 1);
    tick();
    agent_en = 1'b0;
    reset    = 1'b1;
    clear_agent();
    @(negedge clk);
    check_zero("mid_reset");
    start_run();
    spurious = 1'b1;
    repeat (3) tick();
    check("late_mvalid", bus.program_mem_read_valid, 0);
    check("late_busy", busy, 0);
    check("late_ready", bus.consumer_read_ready, 0);
    check("late_data", bus.consumer_read_data, 0);
    mem_lat = 2;
    expect_grant(1, 8'h33);
    req(1, 8'h33);
    wait_pulses(pulses + 1, 50);
    wait_idle(20);
    check("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/program_mem_arbiter.md
Name: program_mem_arbiter

Overview:
- Shares one program-memory read channel among NUM_CONSUMERS fetch units, one per core.
- Consumer side uses the fetch unit's valid/ready protocol: the requester holds valid and address, receives a one-cycle ready pulse with data, then drops valid.
- Memory side presents a single valid/address request and waits for ready/data.
- Round-robin arbitration; one outstanding memory transaction at a time.

Parameters:
- NUM_CONSUMERS, 4, number of fetch units sharing the channel (>=1).
- PROGRAM_MEM_ADDR_BITS, 8, instruction address width.
- PROGRAM_MEM_DATA_BITS, 16, instruction width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- consumer_read_valid  in  [NUM_CONSUMERS-1:0]  per-consumer request.
- consumer_read_address  in  [NUM_CONSUMERS-1:0][PROGRAM_MEM_ADDR_BITS-1:0]  per-consumer address.
- consumer_read_ready  out  [NUM_CONSUMERS-1:0]  per-consumer one-cycle completion pulse.
- consumer_read_data  out  [NUM_CONSUMERS-1:0][PROGRAM_MEM_DATA_BITS-1:0]  per-consumer returned instruction.
- program_mem_read_valid  out  1  request to program memory.
- program_mem_read_address  out  PROGRAM_MEM_ADDR_BITS  memory address.
- program_mem_read_ready  in  1  memory data valid.
- program_mem_read_data  in  PROGRAM_MEM_DATA_BITS  memory data.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  $clog2(NUM_CONSUMERS) (min 1)  index of the consumer currently served.

Behaviour:
- Reset (synchronous, high): all outputs 0, state IDLE, rr_ptr 0. Applies even mid-transaction; any in-flight memory response is discarded and never relayed.
- All outputs are registered.
- States: IDLE, MEM_WAIT, RELAY, RELEASE.
- IDLE:
  - If any consumer_read_valid is set, select g = first set bit searching rr_ptr, rr_ptr+1, … modulo NUM_CONSUMERS.
  - Next cycle: program_mem_read_valid=1, program_mem_read_address=consumer_read_address[g], grant_id=g, busy=1, state MEM_WAIT.
  - program_mem_read_ready is ignored in IDLE.
- MEM_WAIT:
  - valid and address held stable until program_mem_read_ready=1.
  - On ready: program_mem_read_valid<=0, consumer_read_data[g]<=program_mem_read_data, consumer_read_ready[g]<=1, state RELAY.
  - Changes on consumer inputs during MEM_WAIT are ignored; the address was captured at grant.
- RELAY: consumer_read_ready[g]<=0 (pulse exactly one cycle), state RELEASE.
- RELEASE:
  - Wait until consumer_read_valid[g]==0. A fetch unit drops valid about two cycles after the ready pulse; that stale valid must not start a new transaction.
  - On low: state IDLE, busy<=0, rr_ptr<=(g+1) mod NUM_CONSUMERS.
  - No timeout.
- consumer_read_data[i] holds its last value until overwritten by a later grant to i. Other consumers' data and ready are untouched.
- Only one bit of consumer_read_ready is ever high.
- Minimum turnaround from request to ready pulse: 2 cycles plus memory latency.
- Back-to-back grants are separated by at least one IDLE cycle.
- NUM_CONSUMERS=1 degenerates to pass-through with the same state sequence.

Test Plan:
1. Reset: assert reset 2 cycles with random inputs -> all outputs 0, busy 0; deassert -> IDLE, no memory request while all valids are 0.
2. Single request: consumer 2, valid, addr 0x15; memory asserts ready with data 0xA5C3 three cycles after program_mem_read_valid rises.
   - program_mem_read_valid rises one cycle after the request, with address 0x15 and grant_id 2.
   - consumer_read_ready = 4'b0100 for exactly one cycle after memory ready; consumer_read_data[2] = 0xA5C3.
   - Data of consumers 0, 1 and 3 unchanged.
3. Simultaneous requests: all four valid at once, addresses 0x10-0x13, memory latency 1 -> grant order 0,1,2,3 with matching addresses; then consumers 0 and 3 request -> 0 served first (rr_ptr wrapped to 0).
4. Fairness: consumer 1 re-asserts valid immediately after each release while consumer 3 is waiting; rr_ptr 1 -> grant 1 then 3 then 1; consumer 3 is never starved.
5. Stale valid and spurious ready:
   - Consumer 0 holds valid 3 cycles after its ready pulse -> exactly one memory transaction and no second ready pulse.
   - program_mem_read_ready pulsed in IDLE -> no effect on any output.
6. Reset mid-operation: assert reset in MEM_WAIT (addr 0x22 outstanding) -> next cycle all outputs 0, rr_ptr 0. A later memory ready is ignored; after reset deasserts, consumer 1 alone requesting is granted normally.
